// File: rtl/sar_pkg.sv
// Shared SAR constants and the oversampling-select encoding.
// Reused by the averager and by the SAR logic benches.
package sar_pkg;

    localparam int unsigned SAR_W   = 10;
    localparam int unsigned ACC_W   = 13;
    localparam int unsigned OSR_MAX = 3;

    typedef enum logic [1:0] {
        OSR_1 = 2'd0,
        OSR_2 = 2'd1,
        OSR_4 = 2'd2,
        OSR_8 = 2'd3
    } osr_e;

    // Value of the sample counter on the capture that closes a 2^osr window.
    function automatic logic [OSR_MAX-1:0] win_last(input osr_e osr);
        return OSR_MAX'((1 << osr) - 1);
    endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot on the same edge.
module sar_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers are exactly PW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sar_result_averager.sv
// Captures SAR codes on rising eoc, averages 2^osr of them, and queues the
// truncated averages in a result FIFO with a sticky drop flag.
module sar_result_averager #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SAR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       eoc,
    input  logic [SAR_W-1:0]           sar,
    input  logic [1:0]                 osr,
    input  logic                       clr_ovf,
    output logic [SAR_W-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     level
);

    import sar_pkg::*;

    localparam int unsigned SUM_W = SAR_W + 3;

    logic               eoc_d;
    logic               capture;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   sum;
    logic [OSR_MAX-1:0] count;
    osr_e               osr_win;
    osr_e               win;
    logic               last;
    logic               push;
    logic [SAR_W-1:0]   push_data;
    logic               pop;
    logic               full;
    logic               empty;

    assign capture = eoc & ~eoc_d;
    // The first capture of a window uses the live osr, so the window size is known on that same edge.
    assign win       = (count == '0) ? osr_e'(osr) : osr_win;
    assign last      = (count == win_last(win));
    assign sum       = acc + SUM_W'(sar);
    assign push      = capture & last;
    assign push_data = SAR_W'(sum >> win);
    assign pop       = dout_valid & dout_ready;
    assign dout_valid = ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eoc_d   <= 1'b1;
            acc     <= '0;
            count   <= '0;
            osr_win <= OSR_1;
            ovf     <= 1'b0;
        end else begin
            eoc_d <= eoc;
            if (capture) begin
                if (count == '0)
                    osr_win <= osr_e'(osr);
                if (last) begin
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= sum;
                    count <= count + 1'b1;
                end
            end
            if (push & full & ~pop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    sar_result_fifo #(
        .DEPTH (DEPTH),
        .W     (SAR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_sar_result_averager.sv
// Randomised and directed bench for sar_result_averager against a
// queue-based model of capture, windowed averaging and the result FIFO.
module tb_sar_result_averager;

    localparam int DEPTH = 4;
    localparam int SAR_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             eoc = 1'b0;
    logic [SAR_W-1:0] sar = '0;
    logic [1:0]       osr = 2'd0;
    logic             clr_ovf = 1'b0;
    logic             dout_ready = 1'b0;
    logic [SAR_W-1:0] dout;
    logic             dout_valid;
    logic             ovf;
    logic [2:0]       level;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_q[$];
    int m_samples[$];
    int m_win = 0;
    bit m_eoc_d = 1'b1;
    bit m_ovf = 1'b0;
    int got[$];

    sar_result_averager #(
        .DEPTH (DEPTH),
        .SAR_W (SAR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .eoc        (eoc),
        .sar        (sar),
        .osr        (osr),
        .clr_ovf    (clr_ovf),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf        (ovf),
        .level      (level)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour: edge detect, window of 2^osr samples, FIFO as a queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_samples.delete();
            m_win = 0;
            m_eoc_d = 1'b1;
            m_ovf = 1'b0;
        end else begin
            bit cap, pop, have, drop;
            int res, sum, sz;
            cap = eoc && !m_eoc_d;
            m_eoc_d = eoc;
            sz = m_q.size();
            pop = (sz != 0) && dout_ready;
            have = 1'b0;
            drop = 1'b0;
            res = 0;
            if (cap) begin
                if (m_samples.size() == 0) m_win = int'(osr);
                m_samples.push_back(int'(sar));
                if (m_samples.size() == (1 << m_win)) begin
                    sum = 0;
                    foreach (m_samples[i]) sum += m_samples[i];
                    res = sum / (1 << m_win);
                    have = 1'b1;
                    m_samples.delete();
                end
            end
            if (pop) void'(m_q.pop_front());
            if (have) begin
                if (sz < DEPTH || pop) m_q.push_back(res);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    always @(posedge clk)
        if (!rst && dout_valid && dout_ready) got.push_back(int'(dout));

    always @(negedge clk) begin
        check("dout_valid", int'(dout_valid), int'(m_q.size() != 0));
        check("level", int'(level), m_q.size());
        check("ovf", int'(ovf), int'(m_ovf));
        if (m_q.size() != 0) check("dout", int'(dout), m_q[0]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic capture(input int v);
        eoc = 1'b1;
        sar = SAR_W'(v);
        tick();
        eoc = 1'b0;
        tick();
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        dout_ready = 1'b1;
        while (dout_valid && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", 0, 1);
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic check_got(input string name, input int exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        foreach (exp[i])
            if (i < got.size()) check(name, got[i], exp[i]);
    endtask

    initial begin
        #12;
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_ovf", int'(ovf), 0);
        eoc = 1'b1;                 // high at release must not capture
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("no_spurious_capture", int'(dout_valid), 0);
        eoc = 1'b0;
        tick();

        // Pass-through, one result per capture
        osr = 2'd0;
        dout_ready = 1'b1;
        got.delete();
        capture(10'h3FF); capture(10'h000); capture(10'h155); capture(10'h2AA);
        tick();
        check_got("osr0_pass", '{1023, 0, 341, 682});
        dout_ready = 1'b0;

        // Four-sample average, truncated
        osr = 2'd2;
        got.delete();
        capture(100); capture(101); capture(102);
        check("osr2_no_early", int'(dout_valid), 0);
        capture(104);
        check("osr2_avg_literal", int'(dout), 101);
        drain();
        check_got("osr2_avg", '{101});

        // Full-scale eight-sample window
        osr = 2'd3;
        got.delete();
        for (int i = 0; i < 8; i++) capture(10'h3FF);
        drain();
        check_got("osr3_fullscale", '{1023});

        // Overflow: DEPTH+1 results with no consumer
        osr = 2'd0;
        got.delete();
        for (int i = 0; i < DEPTH + 1; i++) capture(11 + i);
        check("ovf_level", int'(level), DEPTH);
        check("ovf_set", int'(ovf), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_cleared", int'(ovf), 0);
        drain();
        check_got("ovf_order", '{11, 12, 13, 14});

        // Push and pop together while full
        got.delete();
        for (int i = 0; i < DEPTH; i++) capture(21 + i);
        eoc = 1'b1;
        sar = 10'd25;
        dout_ready = 1'b1;
        tick();
        eoc = 1'b0;
        dout_ready = 1'b0;
        tick();
        check("full_pushpop_level", int'(level), DEPTH);
        check("full_pushpop_ovf", int'(ovf), 0);
        drain();
        check_got("full_pushpop_order", '{21, 22, 23, 24, 25});

        // Asynchronous reset mid-window with entries queued
        osr = 2'd0;
        capture(1); capture(2);
        osr = 2'd2;
        capture(50); capture(60);
        rst = 1'b1;
        #1;
        check("arst_valid", int'(dout_valid), 0);
        check("arst_level", int'(level), 0);
        tick();
        rst = 1'b0;
        tick();
        got.delete();
        capture(200); capture(201); capture(202); capture(203);
        drain();
        check_got("post_rst_avg", '{201});

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 2) == 0) eoc = ~eoc;
            if (!eoc) sar = SAR_W'($urandom);
            osr        = 2'($urandom);
            dout_ready = ($urandom_range(0, 3) != 0);
            clr_ovf    = ($urandom_range(0, 15) == 0);
            tick();
        end
        eoc = 1'b0;
        clr_ovf = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sar_result_averager.md
SAR_RESULT_AVERAGER -- requirements
Module: sar_result_averager

Interface
REQ-001 Parameter DEPTH, default 4, meaning result FIFO entries; power of two, 2..16.
REQ-002 Parameter SAR_W, default 10, meaning SAR code width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 eoc  input  1  end-of-conversion from SAR logic; level, rising edge marks a new valid code.
REQ-006 sar  input  SAR_W  SAR conversion code; stable while eoc high.
REQ-007 osr  input  2  oversampling select; window = 2^osr samples (1/2/4/8).
REQ-008 clr_ovf  input  1  synchronous clear of sticky overflow flag.
REQ-009 dout  output  SAR_W  averaged result at FIFO head.
REQ-010 dout_valid  output  1  FIFO non-empty; dout is valid.
REQ-011 dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
REQ-012 ovf  output  1  sticky: a result was dropped because the FIFO was full.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Edge detect: capture cycle = eoc==1 & eoc_d==0, eoc_d a registered copy of eoc.
REQ-015 On a capture cycle, sar is sampled on that same clock edge; no other cycle samples sar.
REQ-016 Window: osr latched into osr_win whenever sample count is 0 and a capture occurs; mid-window osr changes have no effect until the next window.
REQ-017 Accumulator width SAR_W+3 bits; never overflows (8 x 1023 = 8184 < 8192).
REQ-018 On the capture completing a window (count == 2^osr_win - 1), result = (acc + sar) >> osr_win, truncated (no rounding), pushed to FIFO on that edge; acc and count return to 0.
REQ-019 osr_win == 0: every capture pushes sar unchanged.
REQ-020 Latency: dout_valid rises one cycle after the completing capture cycle when the FIFO was empty.
REQ-021 FIFO is first-word-fall-through: dout = head entry, dout_valid = (level != 0).
REQ-022 Pop when dout_valid & dout_ready; dout holds its value while dout_valid & !dout_ready.
REQ-023 Push while full and no pop: result dropped, FIFO unchanged, ovf set next cycle.
REQ-024 Push and pop in same cycle while full: both succeed, level unchanged, ovf not set.
REQ-025 Push while empty: stored; cannot pop in the same cycle.
REQ-026 Pointers wrap modulo DEPTH; level never exceeds DEPTH.
REQ-027 ovf set and clr_ovf in same cycle: set wins.
REQ-028 eoc held high: one capture only; eoc must return low before the next capture.

Reset
REQ-029 rst asserted: eoc_d=1 (no spurious capture if eoc high at release), acc=0, count=0, osr_win=0, FIFO empty, level=0, dout_valid=0, dout=0, ovf=0.
REQ-030 rst mid-window or with data in FIFO discards all partial and stored results immediately, without waiting for clk.

Structure
REQ-031 Shared package sar_pkg holds SAR_W=10, ACC_W=13, OSR_MAX=3 and the osr encoding constants, reused by sar_logic_TSCS_10bit benches.
REQ-032 One sub-module sar_result_fifo (DEPTH, width SAR_W, push/pop/full/empty/level); accumulator and edge detect stay in the top.

Verification
REQ-033 osr=0, four eoc pulses with sar=0x3FF,0x000,0x155,0x2AA, dout_ready=1 -> dout 0x3FF,0x000,0x155,0x2AA, each valid one cycle after its capture.
REQ-034 osr=2, sar=100,101,102,104 -> single result 101 (407>>2), no output after first three captures.
REQ-035 osr=3, eight captures of 0x3FF -> result 0x3FF, no accumulator wrap.
REQ-036 osr=0, dout_ready=0, DEPTH+1 captures -> level=4, first four results retained in order, ovf=1; clr_ovf pulse -> ovf=0.
REQ-037 FIFO full, dout_ready=1 in the same cycle as a completing capture -> level stays 4, ovf stays 0, order preserved.
REQ-038 rst pulse after 2 of 4 osr=2 captures and with 2 entries queued -> dout_valid=0, level=0; next 4 captures yield a single correct average.
